// File: rtl/aes_inv_mix_col_seq_if.sv
// Column-in / column-out handshake bundle for the InvMixColumns column engine.
// slave is the engine side, master is the producer/consumer side.
interface aes_inv_mix_col_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] col_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] col_out;
    logic        busy;

    modport slave (
        input  in_valid, col_in, out_ready,
        output in_ready, out_valid, col_out, busy
    );

    modport master (
        output in_valid, col_in, out_ready,
        input  in_ready, out_valid, col_out, busy
    );
endinterface

// File: rtl/aes_inv_mix_col_seq.sv
// Iterative AES InvMixColumns for one 32-bit column, BPC output bytes per cycle.
// The column rotates through BPC shared GF(2^8) byte lanes; results shift into res.

module aes_inv_mix_lane (
    input  logic [31:0] col,
    output logic [7:0]  y
);
    function automatic logic [7:0] xt2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] x1_2, x1_4, x1_8, x2_2, x2_4, x2_8, x3_2, x3_4, x3_8, x0_2, x0_4, x0_8;

    always_comb begin
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        x0_2 = xt2(b0); x0_4 = xt2(x0_2); x0_8 = xt2(x0_4);
        x1_2 = xt2(b1); x1_4 = xt2(x1_2); x1_8 = xt2(x1_4);
        x2_2 = xt2(b2); x2_4 = xt2(x2_2); x2_8 = xt2(x2_4);
        x3_2 = xt2(b3); x3_4 = xt2(x3_2); x3_8 = xt2(x3_4);
        // 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3
        y = (x0_8 ^ x0_4 ^ x0_2)
          ^ (x1_8 ^ x1_2 ^ b1)
          ^ (x2_8 ^ x2_4 ^ b2)
          ^ (x3_8 ^ b3);
    end
endmodule

module aes_inv_mix_col_seq #(
    parameter int BPC = 1
) (
    input logic                  clk,
    input logic                  rst,
    aes_inv_mix_col_seq_if.slave bus
);
    localparam int N = 4 / BPC;
    localparam logic [1:0] CNT_LAST = 2'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
        $error("aes_inv_mix_col_seq: BPC must be 1, 2 or 4");
    end

    function automatic logic [31:0] rotl_bytes(input logic [31:0] x, input int k);
        return (x << (8 * k)) | (x >> (32 - 8 * k));
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] src_q, src_d;
    logic [31:0] res_q, res_d;

    // Lane j handles window byte j; lane 0 lands in the most significant slot.
    logic [BPC-1:0][7:0] lane_out;

    for (genvar j = 0; j < BPC; j++) begin : g_lane
        aes_inv_mix_lane u_lane (
            .col (rotl_bytes(src_q, j)),
            .y   (lane_out[BPC-1-j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    src_d   = bus.col_in;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d = (res_q << (8 * BPC)) | 32'(lane_out);
                src_d = rotl_bytes(src_q, BPC);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            src_q   <= 32'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY) || (state_q == DONE);
    assign bus.col_out   = res_q;
endmodule

// File: tb/tb_aes_inv_mix_col_seq.sv
// Directed and randomized checks of the InvMixColumns column engine at BPC 1, 2 and 4.
module tb_aes_inv_mix_col_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // index 0: BPC=1, 1: BPC=2, 2: BPC=4
    logic        in_valid_t  [3];
    logic [31:0] col_in_t    [3];
    logic        out_ready_t [3];
    logic        in_ready_t  [3];
    logic        out_valid_t [3];
    logic        busy_t      [3];
    logic [31:0] col_out_t   [3];

    aes_inv_mix_col_seq_if if0 ();
    aes_inv_mix_col_seq_if if1 ();
    aes_inv_mix_col_seq_if if2 ();

    assign if0.in_valid = in_valid_t[0]; assign if0.col_in = col_in_t[0]; assign if0.out_ready = out_ready_t[0];
    assign if1.in_valid = in_valid_t[1]; assign if1.col_in = col_in_t[1]; assign if1.out_ready = out_ready_t[1];
    assign if2.in_valid = in_valid_t[2]; assign if2.col_in = col_in_t[2]; assign if2.out_ready = out_ready_t[2];
    assign in_ready_t[0] = if0.in_ready; assign out_valid_t[0] = if0.out_valid; assign busy_t[0] = if0.busy; assign col_out_t[0] = if0.col_out;
    assign in_ready_t[1] = if1.in_ready; assign out_valid_t[1] = if1.out_valid; assign busy_t[1] = if1.busy; assign col_out_t[1] = if1.col_out;
    assign in_ready_t[2] = if2.in_ready; assign out_valid_t[2] = if2.out_valid; assign busy_t[2] = if2.busy; assign col_out_t[2] = if2.col_out;

    aes_inv_mix_col_seq #(.BPC(1)) dut1 (.clk(clk), .rst(rst), .bus(if0));
    aes_inv_mix_col_seq #(.BPC(2)) dut2 (.clk(clk), .rst(rst), .bus(if1));
    aes_inv_mix_col_seq #(.BPC(4)) dut4 (.clk(clk), .rst(rst), .bus(if2));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_model(input logic [31:0] c);
        logic [7:0] b [4];
        logic [7:0] o [4];
        for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            o[i] = gmul(8'h0e, b[i]) ^ gmul(8'h0b, b[(i+1)%4]) ^ gmul(8'h0d, b[(i+2)%4]) ^ gmul(8'h09, b[(i+3)%4]);
        return {o[0], o[1], o[2], o[3]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid_t[s] = 1'b0; col_in_t[s] = 32'h0; out_ready_t[s] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            total += 4;
            if (in_ready_t[s] !== 1'b0) begin bad++; $display("FAIL rst_in_ready[%0d] got=%b want=0", s, in_ready_t[s]); end
            if (out_valid_t[s] !== 1'b0) begin bad++; $display("FAIL rst_out_valid[%0d] got=%b want=0", s, out_valid_t[s]); end
            if (busy_t[s] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got=%b want=0", s, busy_t[s]); end
            if (col_out_t[s] !== 32'h0) begin bad++; $display("FAIL rst_col_out[%0d] got=%h want=0", s, col_out_t[s]); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            total++;
            if (in_ready_t[s] !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready[%0d] got=%b want=1", s, in_ready_t[s]); end
        end
    endtask

    // Entered and left at #1 after an edge with the selected engine in IDLE.
    task automatic test_vector(input int s, input logic [31:0] col, input logic [31:0] exp, input int lat);
        int n = 0;
        col_in_t[s] = col; in_valid_t[s] = 1'b1; out_ready_t[s] = 1'b1;
        @(posedge clk); #1;
        in_valid_t[s] = 1'b0; col_in_t[s] = ~col;
        while (out_valid_t[s] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total += 4;
        if (n != lat) begin bad++; $display("FAIL latency[%0d] col=%h got=%0d want=%0d", s, col, n, lat); end
        if (col_out_t[s] !== exp) begin bad++; $display("FAIL col_out[%0d] col=%h got=%h want=%h", s, col, col_out_t[s], exp); end
        @(posedge clk); #1;
        if (out_valid_t[s] !== 1'b0) begin bad++; $display("FAIL release_out_valid[%0d] got=%b want=0", s, out_valid_t[s]); end
        if (in_ready_t[s] !== 1'b1) begin bad++; $display("FAIL release_in_ready[%0d] got=%b want=1", s, in_ready_t[s]); end
    endtask

    task automatic test_backpressure(input int s);
        int n = 0;
        col_in_t[s] = 32'h8e4da1bc; in_valid_t[s] = 1'b1; out_ready_t[s] = 1'b0;
        @(posedge clk); #1;
        in_valid_t[s] = 1'b0;
        while (out_valid_t[s] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid_t[s] = 1'b1; col_in_t[s] = 32'h01020304 + i;
            @(posedge clk); #1;
            total += 3;
            if (out_valid_t[s] !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] cyc=%0d got=%b want=1", s, i, out_valid_t[s]); end
            if (col_out_t[s] !== 32'hdb135345) begin bad++; $display("FAIL bp_col_out[%0d] cyc=%0d got=%h want=db135345", s, i, col_out_t[s]); end
            if (in_ready_t[s] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] cyc=%0d got=%b want=0", s, i, in_ready_t[s]); end
        end
        in_valid_t[s] = 1'b0; out_ready_t[s] = 1'b1;
        @(posedge clk); #1;
        total += 3;
        if (out_valid_t[s] !== 1'b0) begin bad++; $display("FAIL bp_rel_out_valid[%0d] got=%b want=0", s, out_valid_t[s]); end
        if (busy_t[s] !== 1'b0) begin bad++; $display("FAIL bp_rel_busy[%0d] got=%b want=0", s, busy_t[s]); end
        if (in_ready_t[s] !== 1'b1) begin bad++; $display("FAIL bp_rel_in_ready[%0d] got=%b want=1", s, in_ready_t[s]); end
    endtask

    task automatic test_reset_mid_busy();
        col_in_t[0] = 32'h9fdc589d; in_valid_t[0] = 1'b1; out_ready_t[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_t[0] = 1'b0;
        @(posedge clk); #1;
        // second BUSY cycle; reset arrives together with a new in_valid
        rst = 1'b1; in_valid_t[0] = 1'b1; col_in_t[0] = 32'hc6c6c6c6;
        @(posedge clk); #1;
        total += 4;
        if (out_valid_t[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid_t[0]); end
        if (col_out_t[0] !== 32'h0) begin bad++; $display("FAIL mid_rst_col_out got=%h want=0", col_out_t[0]); end
        if (busy_t[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_t[0]); end
        if (in_ready_t[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready_t[0]); end
        rst = 1'b0; in_valid_t[0] = 1'b0;
        @(posedge clk); #1;
        total += 2;
        if (busy_t[0] !== 1'b0) begin bad++; $display("FAIL rst_wins_busy got=%b want=0", busy_t[0]); end
        if (in_ready_t[0] !== 1'b1) begin bad++; $display("FAIL rst_wins_in_ready got=%b want=1", in_ready_t[0]); end
        test_vector(0, 32'h8e4da1bc, 32'hdb135345, 4);
    endtask

    task automatic test_back_to_back(input int s, input int ncols);
        logic [31:0] exp_q [$];
        int sent = 0;
        int taken = 0;
        int cyc = 0;
        bit acc_prev = 1'b0;
        in_valid_t[s] = 1'b0;
        while (taken < ncols && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (acc_prev) in_valid_t[s] = 1'b0;
            acc_prev = 1'b0;
            if (in_valid_t[s] !== 1'b1 && sent < ncols && $urandom_range(0, 1) == 1) begin
                col_in_t[s] = $urandom; in_valid_t[s] = 1'b1;
            end
            out_ready_t[s] = ($urandom_range(0, 2) != 0);
            if (in_valid_t[s] && in_ready_t[s]) begin
                exp_q.push_back(inv_mix_model(col_in_t[s]));
                sent++;
                acc_prev = 1'b1;
            end
            if (out_valid_t[s] && out_ready_t[s]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious[%0d] got=%h want=none", s, col_out_t[s]);
                end else begin
                    if (col_out_t[s] !== exp_q[0]) begin
                        bad++; $display("FAIL b2b_col_out[%0d] n=%0d got=%h want=%h", s, taken, col_out_t[s], exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                taken++;
            end
        end
        total++;
        if (taken < ncols) begin bad++; $display("FAIL b2b_timeout[%0d] got=%0d want=%0d", s, taken, ncols); end
        in_valid_t[s] = 1'b0; out_ready_t[s] = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_vector(0, 32'h8e4da1bc, 32'hdb135345, 4);
        test_vector(1, 32'h8e4da1bc, 32'hdb135345, 2);
        test_vector(2, 32'h9fdc589d, 32'hf20a225c, 1);
        test_vector(0, 32'h9fdc589d, 32'hf20a225c, 4);
        test_vector(0, 32'h01010101, 32'h01010101, 4);
        test_vector(1, 32'hc6c6c6c6, 32'hc6c6c6c6, 2);
        test_vector(2, 32'h01010101, 32'h01010101, 1);
        test_vector(2, 32'hc6c6c6c6, 32'hc6c6c6c6, 1);
        test_backpressure(0);
        test_backpressure(2);
        test_reset_mid_busy();
        test_back_to_back(0, 20);
        test_back_to_back(1, 20);
        test_back_to_back(2, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
